// File: rtl/ram2video_if.sv
// ram2video_if
//   Groups the line-buffer RAM read port and the video output bundle.
//   master: the ram2video read side (drives address/enable and video out).
//   slave : the RAM plus encoder side (drives read data, consumes video).
//   Signals:
//     rdaddr  RAM read address (ADDR_BITS wide)
//     rden    RAM read enable
//     rddata  RAM read data {R,G,B}
//     R,G,B   output pixel, 0 outside de
//     hsync   horizontal sync, active low
//     vsync   vertical sync, active low
//     de      data enable, high in visible area
interface ram2video_if #(
  parameter int ADDR_BITS = 15
);
  logic [ADDR_BITS-1:0] rdaddr;
  logic                 rden;
  logic [23:0]          rddata;
  logic [7:0]           R;
  logic [7:0]           G;
  logic [7:0]           B;
  logic                 hsync;
  logic                 vsync;
  logic                 de;

  modport master (
    output rdaddr, rden, R, G, B, hsync, vsync, de,
    input  rddata
  );

  modport slave (
    input  rdaddr, rden, R, G, B, hsync, vsync, de,
    output rddata
  );
endinterface

// File: rtl/ram2video.sv
// ram2video
//   Read side of the capture line buffer. After the writer's start trigger it
//   runs a free-running video timing generator and reads the buffer RAM in
//   raster order, emitting RGB with hsync/vsync/de for the HDMI transmitter.
//   Ports:
//     clock         pixel clock, sole clock domain
//     reset_n       synchronous reset, active low
//     starttrigger  one-cycle start pulse from the writer (IDLE only)
//     line_doubler  1: every buffer line is shown twice (sampled per frame)
//     bus           ram2video_if.master: rdaddr/rden/rddata + R/G/B/hsync/vsync/de
//   Read latency model: rddata for the address issued in cycle c is expected
//   in cycle c+RD_LATENCY-1; the last clock of RD_LATENCY is the pixel output
//   register, so the pixel for address A appears with de in cycle rden(A)+RD_LATENCY.
//   RD_LATENCY must be at least 2.
module ram2video #(
  parameter int RAM_ADDRESS_BITS   = 15,
  parameter int BUFFER_LINE_LENGTH = 640,
  parameter int RAM_NUMWORDS       = 20480,
  parameter int H_VISIBLE          = 640,
  parameter int H_FRONT            = 16,
  parameter int H_SYNC             = 96,
  parameter int H_BACK             = 48,
  parameter int V_VISIBLE          = 480,
  parameter int V_FRONT            = 10,
  parameter int V_SYNC             = 2,
  parameter int V_BACK             = 33,
  parameter int RD_LATENCY         = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         starttrigger,
  input  logic         line_doubler,
  ram2video_if.master  bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int AW      = RAM_ADDRESS_BITS;

  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_VIS      = XW'(H_VISIBLE);
  localparam logic [XW-1:0] X_VIS_LAST = XW'(H_VISIBLE - 1);
  localparam logic [XW-1:0] X_HS_BEG   = XW'(H_VISIBLE + H_FRONT);
  localparam logic [XW-1:0] X_HS_END   = XW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_VIS      = YW'(V_VISIBLE);
  localparam logic [YW-1:0] Y_VS_BEG   = YW'(V_VISIBLE + V_FRONT);
  localparam logic [YW-1:0] Y_VS_END   = YW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [AW-1:0] A_LINE     = AW'(BUFFER_LINE_LENGTH);
  localparam logic [AW-1:0] A_WRAP     = AW'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;
  logic [AW-1:0]         base_r;
  logic                  ld_r;
  logic [AW-1:0]         rdaddr_r;
  logic                  rden_r;
  logic                  de_raw_r;
  logic                  hs_raw_r;
  logic                  vs_raw_r;
  logic [RD_LATENCY-1:0] de_pipe_r;
  logic [RD_LATENCY-1:0] hs_pipe_r;
  logic [RD_LATENCY-1:0] vs_pipe_r;
  logic [23:0]           rgb_r;

  state_t                state_nxt_s;
  logic [XW-1:0]         x_nxt_s;
  logic [YW-1:0]         y_nxt_s;
  logic [AW-1:0]         base_nxt_s;
  logic                  ld_nxt_s;
  logic                  run_nxt_s;
  logic                  vis_nxt_s;
  logic                  hs_nxt_s;
  logic                  vs_nxt_s;
  logic [AW-1:0]         rdaddr_nxt_s;

  // Next-state of the timing generator. Everything registered (rden, rdaddr,
  // raw timing) is derived from these next values so it lines up with the
  // counters in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    base_nxt_s  = base_r;
    ld_nxt_s    = ld_r;
    case (state_r)
      ST_IDLE: begin
        x_nxt_s    = {XW{1'b0}};
        y_nxt_s    = {YW{1'b0}};
        base_nxt_s = {AW{1'b0}};
        if (starttrigger) begin
          state_nxt_s = ST_RUN;
          ld_nxt_s    = line_doubler;
        end else begin
          state_nxt_s = ST_IDLE;
          ld_nxt_s    = ld_r;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        if (x_r == X_LAST) begin
          x_nxt_s = {XW{1'b0}};
          if (y_r == Y_LAST) begin
            y_nxt_s = {YW{1'b0}};
          end else begin
            y_nxt_s = y_r + {{(YW-1){1'b0}}, 1'b1};
          end
        end else begin
          x_nxt_s = x_r + {{(XW-1){1'b0}}, 1'b1};
          y_nxt_s = y_r;
        end
        // Frame start reloads the base and resamples the doubler; the last
        // visible pixel of a line advances the base for the following line
        // (only after the odd line when doubling).
        if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
          base_nxt_s = {AW{1'b0}};
          ld_nxt_s   = line_doubler;
        end else if ((x_r == X_VIS_LAST) && (y_r < Y_VIS) && (!ld_r || y_r[0])) begin
          if (base_r < A_WRAP) begin
            base_nxt_s = base_r + A_LINE;
          end else begin
            base_nxt_s = {AW{1'b0}};
          end
        end else begin
          base_nxt_s = base_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        x_nxt_s     = {XW{1'b0}};
        y_nxt_s     = {YW{1'b0}};
        base_nxt_s  = {AW{1'b0}};
        ld_nxt_s    = 1'b0;
      end
    endcase
  end

  // Read request and raw timing decoded from the next counter values.
  always_comb begin
    run_nxt_s    = (state_nxt_s == ST_RUN);
    vis_nxt_s    = run_nxt_s && (x_nxt_s < X_VIS) && (y_nxt_s < Y_VIS);
    hs_nxt_s     = !(run_nxt_s && (x_nxt_s >= X_HS_BEG) && (x_nxt_s < X_HS_END));
    vs_nxt_s     = !(run_nxt_s && (y_nxt_s >= Y_VS_BEG) && (y_nxt_s < Y_VS_END));
    rdaddr_nxt_s = base_nxt_s + AW'(x_nxt_s);
  end

  // Timing generator, read port and the output alignment pipeline.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      base_r    <= {AW{1'b0}};
      ld_r      <= 1'b0;
      rdaddr_r  <= {AW{1'b0}};
      rden_r    <= 1'b0;
      de_raw_r  <= 1'b0;
      hs_raw_r  <= 1'b1;
      vs_raw_r  <= 1'b1;
      de_pipe_r <= {RD_LATENCY{1'b0}};
      hs_pipe_r <= {RD_LATENCY{1'b1}};
      vs_pipe_r <= {RD_LATENCY{1'b1}};
      rgb_r     <= 24'h000000;
    end else begin
      state_r  <= state_nxt_s;
      x_r      <= x_nxt_s;
      y_r      <= y_nxt_s;
      base_r   <= base_nxt_s;
      ld_r     <= ld_nxt_s;
      rden_r   <= vis_nxt_s;
      // Address holds outside the visible area.
      if (vis_nxt_s) begin
        rdaddr_r <= rdaddr_nxt_s;
      end else begin
        rdaddr_r <= rdaddr_r;
      end
      de_raw_r <= vis_nxt_s;
      hs_raw_r <= hs_nxt_s;
      vs_raw_r <= vs_nxt_s;
      if (RD_LATENCY > 1) begin
        de_pipe_r <= {de_pipe_r[RD_LATENCY-2:0], de_raw_r};
        hs_pipe_r <= {hs_pipe_r[RD_LATENCY-2:0], hs_raw_r};
        vs_pipe_r <= {vs_pipe_r[RD_LATENCY-2:0], vs_raw_r};
      end else begin
        de_pipe_r <= {RD_LATENCY{de_raw_r}};
        hs_pipe_r <= {RD_LATENCY{hs_raw_r}};
        vs_pipe_r <= {RD_LATENCY{vs_raw_r}};
      end
      // Pixel register loads with the de value that will be shown next.
      if (de_pipe_r[(RD_LATENCY > 1) ? RD_LATENCY-2 : 0]) begin
        rgb_r <= bus.rddata;
      end else begin
        rgb_r <= 24'h000000;
      end
    end
  end

  assign bus.rdaddr = rdaddr_r;
  assign bus.rden   = rden_r;
  assign bus.R      = rgb_r[23:16];
  assign bus.G      = rgb_r[15:8];
  assign bus.B      = rgb_r[7:0];
  assign bus.de     = de_pipe_r[RD_LATENCY-1];
  assign bus.hsync  = hs_pipe_r[RD_LATENCY-1];
  assign bus.vsync  = vs_pipe_r[RD_LATENCY-1];

endmodule

// File: tb/tb_ram2video.sv
// tb_ram2video
//   Scoreboard bench for ram2video using reduced timing so full frames fit in a
//   short run. A behavioural model predicts rden/rdaddr every cycle from a
//   closed-form raster position and queues the expected video word, which is
//   popped RD_LATENCY cycles later and compared against the DUT outputs.
module tb_ram2video;

  localparam int AW  = 8;
  localparam int LEN = 16;
  localparam int NW  = 64;
  localparam int HV  = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV  = 12, VF = 2, VS = 2, VB = 3;
  localparam int LAT = 2;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NL  = NW / LEN;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vid_t;

  logic clock;
  logic reset_n;
  logic starttrigger;
  logic line_doubler;

  ram2video_if #(.ADDR_BITS(AW)) bus ();

  ram2video #(
    .RAM_ADDRESS_BITS(AW), .BUFFER_LINE_LENGTH(LEN), .RAM_NUMWORDS(NW),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .RD_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .starttrigger(starttrigger),
    .line_doubler(line_doubler), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic          m_run = 1'b0;
  int            m_x = 0, m_y = 0;
  logic          m_ld = 1'b0;
  logic [AW-1:0] m_rdaddr = '0;
  logic [AW:0]   exp_rd;
  vid_t          exp_vid;
  vid_t          exp_q[$];

  // per-frame observed statistics
  logic win_valid = 1'b0;
  int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

  function automatic logic [23:0] ram_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, a, ~a};
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM read port: one register stage ahead of the DUT pixel register.
  always @(posedge clock) bus.rddata <= ram_word(bus.rdaddr);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Advance the model across the next clock edge using the applied inputs.
  task automatic model_update();
    logic vis;
    int   bl;
    logic [AW-1:0] addr;
    vid_t v;
    if (!reset_n) begin
      m_run = 1'b0; m_x = 0; m_y = 0; m_rdaddr = '0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(vid_t'{1'b0, 1'b1, 1'b1, 24'h0});
    end else if (!m_run) begin
      if (starttrigger) begin
        m_run = 1'b1; m_x = 0; m_y = 0; m_ld = line_doubler;
      end
    end else begin
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
      if (m_x == 0 && m_y == 0) m_ld = line_doubler;
    end
    vis  = m_run && (m_x < HV) && (m_y < VV);
    bl   = m_ld ? (m_y / 2) : m_y;
    addr = AW'(((bl % NL) * LEN) + m_x);
    if (vis) m_rdaddr = addr;
    exp_rd = {vis, m_rdaddr};
    v.de  = vis;
    v.hs  = !(m_run && (m_x >= HV + HF) && (m_x < HV + HF + HS));
    v.vs  = !(m_run && (m_y >= VV + VF) && (m_y < VV + VF + VS));
    v.rgb = vis ? ram_word(addr) : 24'h0;
    exp_q.push_back(v);
    exp_vid = exp_q.pop_front();
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    @(negedge clock);
    check_val("rden_rdaddr", 64'({bus.rden, bus.rdaddr}), 64'(exp_rd));
    check_val("video", 64'({bus.de, bus.hsync, bus.vsync, bus.R, bus.G, bus.B}), 64'(exp_vid));
    if (m_run && m_x == 0 && m_y == 0) begin
      if (win_valid) begin
        check_val("frame_de_count", 64'(de_cnt), 64'(HV * VV));
        check_val("frame_hsync_low", 64'(hs_cnt), 64'(HS * VT));
        check_val("frame_vsync_low", 64'(vs_cnt), 64'(VS * HT));
      end
      win_valid = 1'b1;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end else if (!m_run) begin
      win_valid = 1'b0;
    end
    if (bus.de) de_cnt++;
    if (!bus.hsync) hs_cnt++;
    if (!bus.vsync) vs_cnt++;
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; starttrigger = 1'b0; line_doubler = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2000) step();
    check_val("idle_rdaddr", 64'(bus.rdaddr), 64'd0);

    // first frame start, no doubling; run through the buffer wrap and two frames
    starttrigger = 1'b1; step(); starttrigger = 1'b0;
    repeat (2 * FRAME + 50) step();

    // trigger while running must not restart the raster
    starttrigger = 1'b1; step(); starttrigger = 1'b0;
    repeat (100) step();

    // doubling from the next frame, then toggled off mid-frame
    line_doubler = 1'b1;
    repeat (FRAME + FRAME / 2) step();
    line_doubler = 1'b0;
    repeat (FRAME) step();

    // reset in the middle of a visible line, then restart
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_run && m_y == 3 && m_x == 10) found = 1'b1;
      else step();
    end
    check_val("wait_mid_line", 64'(found), 64'd1);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check_val("reset_mid_rden", 64'(bus.rden), 64'd0);
    check_val("reset_mid_rdaddr", 64'(bus.rdaddr), 64'd0);
    repeat (20) step();
    starttrigger = 1'b1; step(); starttrigger = 1'b0;
    check_val("restart_addr0", 64'({bus.rden, bus.rdaddr}), 64'({1'b1, 8'd0}));
    repeat (FRAME + 20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
